// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD host: opcodes, FSM states, and frame geometry.
package lcd_pkg;

  localparam logic [3:0] CMD_WRITE       = 4'd0;
  localparam logic [3:0] CMD_SHIFT_UP    = 4'd1;
  localparam logic [3:0] CMD_SHIFT_DOWN  = 4'd2;
  localparam logic [3:0] CMD_SHIFT_LEFT  = 4'd3;
  localparam logic [3:0] CMD_SHIFT_RIGHT = 4'd4;
  localparam logic [3:0] CMD_MAX         = 4'd5;
  localparam logic [3:0] CMD_MIN         = 4'd6;
  localparam logic [3:0] CMD_AVG         = 4'd7;
  localparam logic [3:0] CMD_ROT_CCW     = 4'd8;
  localparam logic [3:0] CMD_ROT_CW      = 4'd9;
  localparam logic [3:0] CMD_MIRROR_X    = 4'd10;
  localparam logic [3:0] CMD_MIRROR_Y    = 4'd11;
  localparam logic [3:0] CMD_MAX_OP      = 4'd11;

  localparam int unsigned NPIX      = 64;
  localparam int unsigned PIX_AW    = 6;
  localparam int unsigned PIX_SLOTS = 1 << PIX_AW;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GUARD,
    COLLECT,
    DONE
  } host_state_t;

  function automatic logic cmd_legal(input logic [3:0] op);
    return op <= CMD_MAX_OP;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO, DEPTH x WIDTH, registered storage (no fall-through).
// Writes when full and reads when empty are ignored.
module lcd_cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/lcd_cmd_host.sv
// Host-side command issuer and IRAM image sink for the LCD controller.
// Optional watchdog built when LCD_HOST_TIMEOUT_EN is defined.
module lcd_cmd_host
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned HOLDOFF = 2,
  parameter int unsigned NPIX    = lcd_pkg::NPIX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_valid,
  input  logic [3:0]  push_cmd,
  output logic        push_ready,
  input  logic        busy,
  input  logic        done,
  output logic [3:0]  cmd,
  output logic        cmd_valid,
  input  logic        IRAM_valid,
  input  logic [5:0]  IRAM_A,
  input  logic [7:0]  IRAM_D,
  output logic        frame_done,
  output logic [15:0] checksum,
  output logic [6:0]  pix_count,
  output logic        err_dup,
  output logic        err_miss,
  output logic        err_bad_cmd,
  output logic        timeout
);

  localparam int unsigned HOLD = (HOLDOFF == 0) ? 1 : HOLDOFF;
  localparam int unsigned GW   = $clog2(HOLD + 1);

  host_state_t          state, state_nx;
  logic [3:0]           head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                 push_fire;
  logic                 fifo_wr;
  logic                 pop;
  logic [GW-1:0]        guard_cnt;
  logic                 guard_last;
  logic                 wr_pix;
  logic [PIX_SLOTS-1:0] bitmap, bitmap_nx;
  logic [6:0]           pix_nx;
  logic                 force_done;

  // push_ready derives from the registered count, so a same-cycle pop cannot admit a push.
  assign push_ready = !fifo_full && (state != DONE);
  assign push_fire  = push_valid && push_ready;
  assign fifo_wr    = push_fire && cmd_legal(push_cmd);
  assign cmd_valid  = (state == ISSUE);
  assign guard_last = (guard_cnt == GW'(HOLD - 1));
  assign wr_pix     = (state == COLLECT) && IRAM_valid;

  lcd_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (push_cmd),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic and FIFO pop.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE:    if (!busy && (fifo_count != '0)) state_nx = ISSUE;
      ISSUE: begin
        pop      = !fifo_empty;
        state_nx = (cmd == CMD_WRITE) ? COLLECT : GUARD;
      end
      GUARD:   if (guard_last) state_nx = IDLE;
      COLLECT: if (done) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (force_done) state_nx = DONE;
  end

  // Opcode latched on entry to ISSUE and held afterwards.
  always_ff @(posedge clk) begin
    if (reset)                                    cmd <= '0;
    else if (state == IDLE && state_nx == ISSUE)  cmd <= head;
  end

  // Guard-interval counter, cleared whenever not in GUARD.
  always_ff @(posedge clk) begin
    if (reset || state != GUARD) guard_cnt <= '0;
    else                         guard_cnt <= guard_cnt + 1'b1;
  end

  // Coverage and count including this cycle's write, so a write alongside done is counted.
  always_comb begin
    bitmap_nx = bitmap;
    pix_nx    = pix_count;
    if (wr_pix) begin
      bitmap_nx[IRAM_A] = 1'b1;
      if (pix_count != 7'd127) pix_nx = pix_count + 1'b1;
    end
  end

  // Frame capture, error flags and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      bitmap      <= '0;
      checksum    <= '0;
      pix_count   <= '0;
      err_dup     <= 1'b0;
      err_miss    <= 1'b0;
      err_bad_cmd <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      bitmap    <= bitmap_nx;
      pix_count <= pix_nx;
      if (wr_pix) begin
        checksum <= checksum + {8'd0, IRAM_D};
        if (bitmap[IRAM_A]) err_dup <= 1'b1;
      end
      if (push_fire && !cmd_legal(push_cmd)) err_bad_cmd <= 1'b1;
      if (state == COLLECT && done)
        err_miss <= (bitmap_nx != '1) || (pix_nx != 7'(NPIX));
      frame_done <= (state_nx == DONE) && (state != DONE);
    end
  end

`ifdef LCD_HOST_TIMEOUT_EN
  logic [11:0] to_cnt;
  logic        to_run;

  assign to_run     = (state == COLLECT) ||
                      (busy && (state == GUARD || (state == IDLE && !fifo_empty)));
  assign force_done = to_run && (to_cnt == 12'hFFF);

  // Watchdog: restarts on any IRAM write, issue or state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (state_nx != state || IRAM_valid || !to_run) to_cnt <= '0;
      else                                            to_cnt <= to_cnt + 1'b1;
      if (force_done) timeout <= 1'b1;
    end
  end
`else
  assign force_done = 1'b0;
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_cmd_host.sv
// Directed self-checking bench for lcd_cmd_host (DEPTH=8, HOLDOFF=2, NPIX=64).
module tb_lcd_cmd_host;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_valid;
  logic [3:0]  push_cmd;
  logic        push_ready;
  logic        busy;
  logic        done;
  logic [3:0]  cmd;
  logic        cmd_valid;
  logic        IRAM_valid;
  logic [5:0]  IRAM_A;
  logic [7:0]  IRAM_D;
  logic        frame_done;
  logic [15:0] checksum;
  logic [6:0]  pix_count;
  logic        err_dup;
  logic        err_miss;
  logic        err_bad_cmd;
  logic        timeout;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_cmd_host #(
    .DEPTH   (8),
    .HOLDOFF (2),
    .NPIX    (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .push_valid  (push_valid),
    .push_cmd    (push_cmd),
    .push_ready  (push_ready),
    .busy        (busy),
    .done        (done),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .IRAM_valid  (IRAM_valid),
    .IRAM_A      (IRAM_A),
    .IRAM_D      (IRAM_D),
    .frame_done  (frame_done),
    .checksum    (checksum),
    .pix_count   (pix_count),
    .err_dup     (err_dup),
    .err_miss    (err_miss),
    .err_bad_cmd (err_bad_cmd),
    .timeout     (timeout)
  );

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic bsy);
    reset = 1'b1; push_valid = 1'b0; push_cmd = '0; busy = bsy;
    done = 1'b0; IRAM_valid = 1'b0; IRAM_A = '0; IRAM_D = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [3:0] c);
    push_valid = 1'b1; push_cmd = c;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic wait_issue(input int unsigned budget, output logic [3:0] c,
                            output int unsigned at, output bit ok);
    ok = 1'b0; c = '0; at = 0;
    for (int unsigned i = 0; i < budget; i++) begin
      tick();
      if (cmd_valid === 1'b1) begin
        c = cmd; at = cyc; ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic drive_writes(input int unsigned n, input int unsigned mult, input bit dup,
                              input bit done_last, input bit send_done);
    logic [5:0] a;
    for (int unsigned i = 0; i < n; i++) begin
      a = 6'(i);
      if (dup && i == 6) a = 6'd5;
      IRAM_valid = 1'b1; IRAM_A = a; IRAM_D = 8'(int'(a) * mult);
      done = done_last && send_done && (i == n - 1);
      tick();
    end
    IRAM_valid = 1'b0; done = 1'b0;
    if (send_done && !done_last) begin
      done = 1'b1; tick(); done = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [33:0] obs;
    reset = 1'b1; push_valid = 1'b0; push_cmd = '0; busy = 1'b0;
    done = 1'b0; IRAM_valid = 1'b0; IRAM_A = '0; IRAM_D = '0;
    tick(); tick();
    obs = {cmd, cmd_valid, frame_done, checksum, pix_count, err_dup, err_miss,
           err_bad_cmd, timeout, push_ready};
    checks++;
    if (obs !== 34'h1) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", obs, 34'h1);
    end
    reset = 1'b0;
  endtask

  task automatic test_busy_order();
    logic [3:0] c1, c2, c3;
    int unsigned t1, t2, t3;
    bit ok1, ok2, ok3, early;
    do_reset(1'b1);
    push(4'd4); push(4'd4); push(4'd0);
    early = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (cmd_valid !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin errors++; $display("FAIL no_issue_while_busy: got cmd_valid=1 expected 0"); end
    busy = 1'b0;
    wait_issue(20, c1, t1, ok1);
    checks++;
    if (!ok1 || c1 !== 4'd4) begin errors++; $display("FAIL issue1: got ok=%0d cmd=%0d expected 4", ok1, c1); end
    tick();
    checks++;
    if (cmd_valid !== 1'b0 || cmd !== 4'd4) begin
      errors++; $display("FAIL strobe_one_cycle: got valid=%b cmd=%0d expected valid=0 cmd=4", cmd_valid, cmd);
    end
    wait_issue(20, c2, t2, ok2);
    checks++;
    if (!ok2 || c2 !== 4'd4 || t2 - t1 != 4) begin
      errors++; $display("FAIL issue2: got ok=%0d cmd=%0d gap=%0d expected cmd=4 gap=4", ok2, c2, t2 - t1);
    end
    wait_issue(20, c3, t3, ok3);
    checks++;
    if (!ok3 || c3 !== 4'd0 || t3 - t2 != 4) begin
      errors++; $display("FAIL issue3: got ok=%0d cmd=%0d gap=%0d expected cmd=0 gap=4", ok3, c3, t3 - t2);
    end
    tick();
    // done arrives with the final write, which must still count toward coverage
    drive_writes(64, 1, 1'b0, 1'b1, 1'b1);
    checks++;
    if (frame_done !== 1'b1 || checksum !== 16'd2016 || pix_count !== 7'd64 ||
        err_miss !== 1'b0 || err_dup !== 1'b0) begin
      errors++;
      $display("FAIL full_frame: got fd=%b sum=%0d pix=%0d miss=%b dup=%b expected fd=1 sum=2016 pix=64 miss=0 dup=0",
               frame_done, checksum, pix_count, err_miss, err_dup);
    end
    IRAM_valid = 1'b1; IRAM_A = 6'd3; IRAM_D = 8'd99;
    tick();
    IRAM_valid = 1'b0;
    checks++;
    if (frame_done !== 1'b0 || push_ready !== 1'b0 || checksum !== 16'd2016 || pix_count !== 7'd64) begin
      errors++;
      $display("FAIL done_hold: got fd=%b rdy=%b sum=%0d pix=%0d expected fd=0 rdy=0 sum=2016 pix=64",
               frame_done, push_ready, checksum, pix_count);
    end
  endtask

  task automatic test_dup_miss();
    logic [3:0] c;
    int unsigned t;
    bit ok;
    do_reset(1'b0);
    push(4'd0);
    wait_issue(20, c, t, ok);
    checks++;
    if (!ok || c !== 4'd0) begin errors++; $display("FAIL dup_issue: got ok=%0d cmd=%0d expected 0", ok, c); end
    tick();
    drive_writes(64, 1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (frame_done !== 1'b1 || err_dup !== 1'b1 || err_miss !== 1'b1 ||
        checksum !== 16'd2015 || pix_count !== 7'd64) begin
      errors++;
      $display("FAIL dup_miss: got fd=%b dup=%b miss=%b sum=%0d pix=%0d expected fd=1 dup=1 miss=1 sum=2015 pix=64",
               frame_done, err_dup, err_miss, checksum, pix_count);
    end
  endtask

  task automatic test_fifo_full();
    logic [3:0] exp_q [8];
    logic [3:0] c;
    int unsigned t;
    bit ok, extra;
    int bad;
    exp_q = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    do_reset(1'b1);
    for (int i = 0; i < 7; i++) push(exp_q[i]);
    checks++;
    if (push_ready !== 1'b1 || err_bad_cmd !== 1'b0) begin
      errors++; $display("FAIL seven_queued: got rdy=%b bad=%b expected rdy=1 bad=0", push_ready, err_bad_cmd);
    end
    push(4'd13);
    checks++;
    if (err_bad_cmd !== 1'b1 || push_ready !== 1'b1) begin
      errors++; $display("FAIL bad_opcode: got bad=%b rdy=%b expected bad=1 rdy=1", err_bad_cmd, push_ready);
    end
    push(exp_q[7]);
    checks++;
    if (push_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", push_ready); end
    push(4'd10);
    checks++;
    if (push_ready !== 1'b0) begin errors++; $display("FAIL ninth_refused: got rdy=%b expected 0", push_ready); end
    busy = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      wait_issue(20, c, t, ok);
      if (!ok || c !== exp_q[i]) begin
        bad++; $display("FAIL fifo_order[%0d]: got ok=%0d cmd=%0d expected %0d", i, ok, c, exp_q[i]);
      end
    end
    checks++;
    if (bad != 0) errors++;
    extra = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cmd_valid !== 1'b0) extra = 1'b1;
    end
    checks++;
    if (extra) begin errors++; $display("FAIL fifo_drained: got extra cmd_valid expected none"); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] c;
    int unsigned t;
    bit ok;
    logic [33:0] obs;
    do_reset(1'b0);
    push(4'd0);
    wait_issue(20, c, t, ok);
    tick();
    drive_writes(30, 1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pix_count !== 7'd30 || checksum !== 16'd435) begin
      errors++; $display("FAIL partial: got pix=%0d sum=%0d expected pix=30 sum=435", pix_count, checksum);
    end
    reset = 1'b1;
    tick();
    obs = {cmd, cmd_valid, frame_done, checksum, pix_count, err_dup, err_miss,
           err_bad_cmd, timeout, push_ready};
    checks++;
    if (obs !== 34'h1) begin
      errors++; $display("FAIL mid_reset: got %h expected %h", obs, 34'h1);
    end
    reset = 1'b0;
    push(4'd0);
    wait_issue(20, c, t, ok);
    tick();
    drive_writes(64, 3, 1'b0, 1'b0, 1'b1);
    checks++;
    if (!ok || frame_done !== 1'b1 || checksum !== 16'd6048 || pix_count !== 7'd64 ||
        err_miss !== 1'b0 || err_dup !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_frame: got fd=%b sum=%0d pix=%0d miss=%b dup=%b expected fd=1 sum=6048 pix=64 miss=0 dup=0",
               frame_done, checksum, pix_count, err_miss, err_dup);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] c;
    int unsigned t, tf;
    bit ok, seen;
    do_reset(1'b0);
    push(4'd0);
    wait_issue(20, c, t, ok);
    seen = 1'b0; tf = 0;
    for (int i = 0; i < 4200; i++) begin
      tick();
      if (frame_done === 1'b1 && !seen) begin seen = 1'b1; tf = cyc; end
    end
`ifdef LCD_HOST_TIMEOUT_EN
    checks++;
    if (!seen || timeout !== 1'b1 || tf - t < 4095 || tf - t > 4098) begin
      errors++; $display("FAIL timeout: got seen=%0d to=%b after=%0d expected seen=1 to=1 after~4096", seen, timeout, tf - t);
    end
`else
    checks++;
    if (seen || timeout !== 1'b0) begin
      errors++; $display("FAIL no_timeout: got seen=%0d to=%b expected seen=0 to=0", seen, timeout);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_busy_order();
    test_dup_miss();
    test_fifo_full();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_host.md
Name: lcd_cmd_host

Overview:
Host-side command issuer and image sink for the LCD image-display controller. It queues 4-bit opcodes from an upstream script or CPU port and issues them to the controller over cmd/cmd_valid, honouring busy. After issuing Write it captures the controller's IRAM write stream, checksums it and checks address coverage, then reports frame completion. It sits between the stimulus/CPU side and the controller, at the opposite end of the cmd/busy/IRAM interface.

Parameters:
DEPTH, 8, command FIFO entries; power of two, minimum 2
HOLDOFF, 2, guard cycles after each cmd_valid pulse before busy is sampled again
NPIX, 64, pixels expected per frame (8x8 image)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
push_valid  in  1  upstream command valid
push_cmd  in  4  upstream opcode (0=Write, 1..4=Shift U/D/L/R, 5=Max, 6=Min, 7=Avg, 8=CCW, 9=CW, 10=MirX, 11=MirY)
push_ready  out  1  FIFO can accept
busy  in  1  controller busy
done  in  1  controller frame-written pulse
cmd  out  4  opcode to controller
cmd_valid  out  1  one-cycle issue strobe
IRAM_valid  in  1  controller write strobe
IRAM_A  in  6  write address
IRAM_D  in  8  write data
frame_done  out  1  one-cycle completion pulse
checksum  out  16  modulo-2^16 sum of captured IRAM_D
pix_count  out  7  number of accepted IRAM writes
err_dup  out  1  sticky: an address was written twice
err_miss  out  1  set at done if coverage is not all 64 addresses
err_bad_cmd  out  1  sticky: opcode >11 pushed (dropped, not queued)
timeout  out  1  see Optional Feature

Behaviour:
- Reset value of every output is 0, except push_ready, which is 1. FIFO is emptied, coverage bitmap is cleared, and the FSM goes to IDLE. A reset mid-frame aborts everything with no partial reporting.
- Push: a push occurs when push_valid && push_ready.
  - Opcode >11: err_bad_cmd is set and the entry is not stored.
  - push_ready = !full && state!=DONE.
- FSM states: IDLE, ISSUE, GUARD, COLLECT, DONE.
- IDLE: wait for !busy && !empty. Busy is high during the controller's image load, which blocks issue.
- ISSUE (1 cycle): pop the FIFO head and drive cmd=head with cmd_valid=1.
  - cmd holds its value after the strobe. cmd_valid is high for exactly 1 cycle.
  - Head==Write goes to COLLECT; otherwise go to GUARD.
- GUARD: count HOLDOFF cycles, then return to IDLE. Back-to-back minimum issue spacing is HOLDOFF+2 cycles.
- COLLECT: on each IRAM_valid:
  - checksum += IRAM_D, zero-extended, wrapping at 16 bits;
  - pix_count increments, saturating at 127;
  - if bitmap[IRAM_A] is already set, err_dup is set; the bitmap bit is then set.
  - Commands pushed during COLLECT stay queued and are never issued.
- On done=1 in COLLECT: goes to DONE.
  - frame_done pulses on the next cycle.
  - err_miss = (bitmap != all ones) || (pix_count != NPIX), evaluated including any IRAM write in the same cycle as done.
- DONE: terminal until reset. Outputs hold; IRAM_valid is ignored.
- Simultaneous push and pop on a full FIFO: the pop frees a slot only on the following cycle, since push_ready is registered from the pre-pop count.
- done outside COLLECT is ignored. IRAM_valid outside COLLECT is ignored.

Optional Feature:
LCD_HOST_TIMEOUT_EN
- Defined: a 12-bit counter runs in GUARD+IDLE (non-empty) while busy stays high, and in COLLECT.
  - It clears on every IRAM_valid, issue, or state change.
  - At 4095 it sets sticky timeout and forces DONE with frame_done pulsed.
- Not defined: no counter is built; timeout is tied to 0.

Decomposition:
- Package lcd_pkg holds:
  - opcode localparams (CMD_WRITE..CMD_MIRROR_Y, CMD_MAX_OP=11);
  - the FSM state enum;
  - NPIX and pixel address width 6.
- Sub-module lcd_cmd_fifo: synchronous FIFO, DEPTH x 4 bits, with full/empty/count outputs and no fall-through.

Test Plan:
- busy held high for 70 cycles after reset, queue {4,4,0}: no cmd_valid before busy falls. Issue order is 4,4,0, with strobes spaced ≥4 cycles apart.
- Write issued, then controller model emits addresses 0..63 with D=addr: checksum=2016, pix_count=64, frame_done one pulse, err_miss=0, err_dup=0.
- Address 5 written twice with address 6 omitted: err_dup=1 and err_miss=1 at frame_done.
- Push 9 commands into DEPTH=8 with none issued (busy high): 9th is refused (push_ready=0). Push opcode 13: err_bad_cmd=1 and FIFO count is unchanged.
- Reset asserted mid-COLLECT after 30 writes: all outputs return to 0 and push_ready=1. A subsequent full frame checksums correctly.
- With LCD_HOST_TIMEOUT_EN: Write issued, no IRAM activity: timeout=1 and frame_done after 4095 cycles. Without the macro, timeout stays 0.
